// File: rtl/frame_strobe_ctrl.sv
// frame_strobe_ctrl: decodes column/frame commands and drives one registered,
// one-hot frame write strobe into the column after a configurable settle time.
// Commands that miss this column or name a frame outside the column are
// counted in a saturating drop counter.
module frame_strobe_ctrl #(
  parameter int         MaxFramesPerCol = 20,
  parameter logic [4:0] ColumnId        = 5'd0,
  parameter int         SetupCycles     = 2,
  parameter int         StrobeCycles    = 1
) (
  input  logic                       CLK,
  input  logic                       resetn,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [31:0]                cmd_data,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic                       busy,
  output logic                       frame_done,
  output logic [7:0]                 drop_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_STROBE = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  // Last count value of each timed state (counter runs 0..N-1)
  localparam logic [3:0] SETUP_LAST  = 4'(SetupCycles - 1);
  localparam logic [3:0] STROBE_LAST = 4'(StrobeCycles - 1);

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [3:0]                 r_cnt;
  logic [3:0]                 w_cnt_nxt;
  logic [4:0]                 r_idx;
  logic [7:0]                 r_drop;
  logic                       r_cmd_ready;
  logic                       r_frame_done;
  logic [MaxFramesPerCol-1:0] r_strobe;

  logic                       w_ready_nxt;
  logic                       w_done_nxt;
  logic [MaxFramesPerCol-1:0] w_strobe_nxt;

  logic [4:0]                 w_col;
  logic [4:0]                 w_fidx;
  logic                       w_target;
  logic                       w_idx_ok;
  logic                       w_cmd_ok;
  logic                       w_accept;
  logic                       w_unused_bits;

  // Command decode; the payload field [21:0] carries nothing for this block
  assign w_col         = cmd_data[31:27];
  assign w_fidx        = cmd_data[26:22];
  assign w_target      = (w_col == ColumnId) || (w_col == 5'h1F);
  assign w_idx_ok      = ({27'd0, w_fidx} < 32'(MaxFramesPerCol));
  assign w_cmd_ok      = w_target && w_idx_ok;
  assign w_accept      = cmd_valid && r_cmd_ready && (r_state == S_IDLE);
  assign w_unused_bits = ^cmd_data[21:0];

  // State register with its dwell counter
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic: timed SETUP and STROBE, single-cycle HOLD
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_cmd_ok) begin
          w_state_nxt = S_SETUP;
          w_cnt_nxt   = 4'd0;
        end
      end
      S_SETUP: begin
        if (r_cnt == SETUP_LAST) begin
          w_state_nxt = S_STROBE;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      S_STROBE: begin
        if (r_cnt == STROBE_LAST) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      S_HOLD: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Output decode from the next state so every output is registered alongside it
  always_comb begin
    w_ready_nxt = (w_state_nxt == S_IDLE);
    w_done_nxt  = (w_state_nxt == S_HOLD);
    for (int k = 0; k < MaxFramesPerCol; k++) begin
      w_strobe_nxt[k] = (w_state_nxt == S_STROBE) && ({27'd0, r_idx} == 32'(k));
    end
  end

  // Output registers; the async clear drops an active strobe immediately
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_cmd_ready  <= 1'b0;
      r_frame_done <= 1'b0;
      r_strobe     <= '0;
    end else begin
      r_cmd_ready  <= w_ready_nxt;
      r_frame_done <= w_done_nxt;
      r_strobe     <= w_strobe_nxt;
    end
  end

  // Frame index capture at acceptance and saturating drop counter
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_idx  <= 5'd0;
      r_drop <= 8'd0;
    end else if (w_accept) begin
      if (w_cmd_ok) begin
        r_idx <= w_fidx;
      end else if (r_drop != 8'hFF) begin
        r_drop <= r_drop + 8'd1;
      end
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign frame_done  = r_frame_done;
  assign FrameStrobe = r_strobe;
  assign drop_count  = r_drop;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_frame_strobe_ctrl.sv
// Bench for frame_strobe_ctrl: a timeline model (accept edge + age in cycles)
// predicts every output each cycle for a default instance; a second instance
// with a 3-cycle strobe exercises reset abort during the strobe.
module tb_frame_strobe_ctrl;
  localparam int MF = 20;
  localparam int S  = 2;
  localparam int T  = 1;

  logic        CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Default instance
  logic        resetn, cmd_valid, cmd_ready, busy, frame_done;
  logic [31:0] cmd_data;
  logic [19:0] FrameStrobe;
  logic [7:0]  drop_count;

  // StrobeCycles = 3 instance
  logic        resetn2, cmd_valid2, cmd_ready2, busy2, frame_done2;
  logic [31:0] cmd_data2;
  logic [19:0] FrameStrobe2;
  logic [7:0]  drop_count2;

  frame_strobe_ctrl #(.MaxFramesPerCol(MF), .ColumnId(5'd0), .SetupCycles(S), .StrobeCycles(T)) u_dut (
    .CLK(CLK), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .FrameStrobe(FrameStrobe), .busy(busy),
    .frame_done(frame_done), .drop_count(drop_count)
  );

  frame_strobe_ctrl #(.MaxFramesPerCol(MF), .ColumnId(5'd0), .SetupCycles(2), .StrobeCycles(3)) u_dut3 (
    .CLK(CLK), .resetn(resetn2), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
    .cmd_data(cmd_data2), .FrameStrobe(FrameStrobe2), .busy(busy2),
    .frame_done(frame_done2), .drop_count(drop_count2)
  );

  int n_vec = 0;
  int n_err = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  // A valid command accepted at edge E: age a = edge - E.
  // busy for a in [0, S+T], strobe for a in [S, S+T-1], done at a = S+T.
  int          m_e = 0, m_start = 0, m_idx = 0, m_drop = 0, m_age = 0;
  bit          m_active = 0, m_ready = 0;
  bit          cap_rst = 0, cap_valid = 0;
  logic [31:0] cap_data = '0;
  logic [4:0]  m_col, m_fi;
  logic [19:0] e_fs;
  bit          e_busy, e_done;

  // Compare process: advance the model by the edge just taken, then check
  always @(negedge CLK) begin
    if (!resetn || !cap_rst) begin
      m_active = 0; m_ready = 0; m_drop = 0;
      e_fs = '0; e_busy = 0; e_done = 0;
    end else begin
      m_e++;
      if (m_ready && cap_valid) begin
        m_col = cap_data[31:27];
        m_fi  = cap_data[26:22];
        if ((m_col == 5'd0 || m_col == 5'd31) && int'(m_fi) < MF) begin
          m_active = 1; m_start = m_e; m_idx = int'(m_fi);
        end else if (m_drop < 255) begin
          m_drop++;
        end
      end
      m_age  = m_e - m_start;
      e_busy = m_active && (m_age <= S + T);
      e_done = m_active && (m_age == S + T);
      e_fs   = (m_active && m_age >= S && m_age < S + T) ? (20'd1 << m_idx) : 20'd0;
      m_ready = !e_busy;
    end
    chk("m_strobe", 32'(FrameStrobe), 32'(e_fs));
    chk("m_busy",   32'(busy),        32'(e_busy));
    chk("m_done",   32'(frame_done),  32'(e_done));
    chk("m_ready",  32'(cmd_ready),   32'(m_ready));
    chk("m_drop",   32'(drop_count),  32'(m_drop));
    cap_rst   = resetn;
    cap_valid = cmd_valid;
    cap_data  = cmd_data;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [4:0] col, input logic [4:0] fi);
    cmd_valid = 1'b1;
    cmd_data  = {col, fi, 22'($urandom)};
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    logic [4:0] rc, rf;
    resetn = 1'b1; cmd_valid = 1'b0; cmd_data = '0;
    resetn2 = 1'b1; cmd_valid2 = 1'b0; cmd_data2 = '0;
    #2 resetn = 1'b0; resetn2 = 1'b0;
    #1;
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    chk("rst_fs", 32'(FrameStrobe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    chk("rst_ready2", 32'(cmd_ready2), 32'd0);
    repeat (3) tick();
    resetn = 1'b1; resetn2 = 1'b1;
    tick();
    chk("ready_first_edge", 32'(cmd_ready), 32'd1);
    chk("ready_first_edge2", 32'(cmd_ready2), 32'd1);

    // Column 0, frame 5
    send(5'd0, 5'd5);
    chk("f5_busy_n", 32'(busy), 32'd1);
    chk("f5_ready_n", 32'(cmd_ready), 32'd0);
    tick();
    chk("f5_fs_n1", 32'(FrameStrobe), 32'd0);
    tick();
    chk("f5_fs_n2", 32'(FrameStrobe), 32'h00020);
    tick();
    chk("f5_fs_n3", 32'(FrameStrobe), 32'd0);
    chk("f5_done_n3", 32'(frame_done), 32'd1);
    tick();
    chk("f5_ready_n4", 32'(cmd_ready), 32'd1);
    chk("f5_done_n4", 32'(frame_done), 32'd0);

    // Broadcast, frame 19; then a non-targeted column
    send(5'h1F, 5'd19);
    tick(); tick();
    chk("bc_fs19", 32'(FrameStrobe), 32'h80000);
    tick(); tick();
    send(5'd3, 5'd7);
    chk("col3_drop", 32'(drop_count), 32'd1);
    chk("col3_busy", 32'(busy), 32'd0);

    // Out-of-range frames on the matching column
    send(5'd0, 5'd20);
    send(5'd0, 5'd31);
    chk("oor_drop", 32'(drop_count), 32'd3);
    chk("oor_busy", 32'(busy), 32'd0);

    // Valid held high with data changing every cycle
    cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cmd_data = {5'd0, 5'(2 + i), 22'($urandom)};
      tick();
      if (i == 2) chk("hold_first_fs", 32'(FrameStrobe), 32'h00004);
      if (i == 7) chk("hold_second_fs", 32'(FrameStrobe), 32'h00080);
    end
    cmd_valid = 1'b0;
    repeat (4) tick();

    // Drop counter saturation
    cmd_valid = 1'b1;
    repeat (300) begin
      cmd_data = {5'd3, 5'($urandom), 22'($urandom)};
      tick();
    end
    chk("sat_drop", 32'(drop_count), 32'd255);
    repeat (5) tick();
    chk("sat_hold", 32'(drop_count), 32'd255);
    chk("sat_busy", 32'(busy), 32'd0);
    cmd_valid = 1'b0;

    // Reset abort during the second strobe cycle (StrobeCycles = 3)
    cmd_valid2 = 1'b1;
    cmd_data2  = {5'd0, 5'd4, 22'd0};
    tick();
    cmd_valid2 = 1'b0;
    tick(); tick();
    chk("ab_fs_first", 32'(FrameStrobe2), 32'h00010);
    tick();
    chk("ab_fs_second", 32'(FrameStrobe2), 32'h00010);
    #1 resetn2 = 1'b0;
    #1;
    chk("ab_fs_cleared", 32'(FrameStrobe2), 32'd0);
    chk("ab_busy_cleared", 32'(busy2), 32'd0);
    chk("ab_ready_cleared", 32'(cmd_ready2), 32'd0);
    #1 resetn2 = 1'b1;
    tick();
    chk("ab_ready_after", 32'(cmd_ready2), 32'd1);
    chk("ab_fs_after", 32'(FrameStrobe2), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("ab_no_done", 32'(frame_done2), 32'd0);
      tick();
    end

    // Randomised traffic with occasional resets
    resetn = 1'b0;
    tick(); tick();
    resetn = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
      end
      cmd_valid = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: rc = 5'd0;
        6, 7:             rc = 5'h1F;
        default:          rc = 5'($urandom);
      endcase
      rf = ($urandom_range(0, 99) < 85) ? 5'($urandom_range(0, 19)) : 5'($urandom_range(20, 31));
      cmd_data = {rc, rf, 22'($urandom)};
      tick();
    end
    cmd_valid = 1'b0;
    repeat (6) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/frame_strobe_ctrl.md
FRAME_STROBE_CTRL -- requirements
Module: frame_strobe_ctrl

Interface
REQ-001 Parameter MaxFramesPerCol, default 20: number of frame strobe lines driven into the column (FrameStrobe width).
REQ-002 Parameter ColumnId, default 0: 5-bit column address this controller answers to.
REQ-003 Parameter SetupCycles, default 2: cycles between command accept and strobe assertion (FrameData settle time), legal range 1..15.
REQ-004 Parameter StrobeCycles, default 1: cycles the selected strobe is held high, legal range 1..15.
REQ-005 CLK  input  1  single clock for all state.
REQ-006 resetn  input  1  reset, asynchronous assert, active-low.
REQ-007 cmd_valid  input  1  a command word is present on cmd_data.
REQ-008 cmd_ready  output  1  the controller accepts the command word this cycle.
REQ-009 cmd_data  input  32  command: [31:27] column select, [26:22] frame index, [21:0] ignored.
REQ-010 FrameStrobe  output  MaxFramesPerCol  one-hot frame write strobe toward the column's tiles, registered.
REQ-011 busy  output  1  a command is in progress (state not IDLE).
REQ-012 frame_done  output  1  one-cycle pulse when a strobe sequence completes.
REQ-013 drop_count  output  8  saturating count of discarded commands.

Function
REQ-014 A command is accepted on a rising CLK edge where cmd_valid=1 and cmd_ready=1; cmd_ready is 1 only in IDLE and is a registered, not combinational, function of state.
REQ-015 A command targets this column when column select equals ColumnId or equals 5'h1F (broadcast).
REQ-016 A command is valid when it targets this column and frame index < MaxFramesPerCol.
REQ-017 States: IDLE, SETUP, STROBE, HOLD.
REQ-018 IDLE -> SETUP on acceptance of a valid command; the frame index is latched at acceptance.
REQ-019 An accepted command that is not valid leaves state in IDLE, asserts no strobe, and increments drop_count by 1; a non-targeted command also increments drop_count.
REQ-020 drop_count saturates at 255 and never wraps.
REQ-021 SETUP lasts exactly SetupCycles cycles, then -> STROBE.
REQ-022 In STROBE, FrameStrobe[latched index] = 1 and all other bits = 0 for exactly StrobeCycles cycles, then -> HOLD.
REQ-023 HOLD lasts exactly 1 cycle with FrameStrobe all 0; frame_done = 1 during that cycle only; then -> IDLE.
REQ-024 FrameStrobe is all 0 in IDLE, SETUP and HOLD; no two FrameStrobe bits are ever high simultaneously.
REQ-025 Latency: for a command accepted at edge N, FrameStrobe rises after edge N+SetupCycles and falls after edge N+SetupCycles+StrobeCycles; cmd_ready returns to 1 after edge N+SetupCycles+StrobeCycles+1.
REQ-026 cmd_data changes while busy have no effect on the in-flight command.
REQ-027 busy = 1 in SETUP, STROBE and HOLD, 0 in IDLE.
REQ-028 Back-to-back valid commands incur one IDLE cycle minimum between HOLD and the next SETUP.

Reset
REQ-029 resetn=0 asynchronously forces state IDLE, FrameStrobe all 0, frame_done 0, busy 0, cmd_ready 0, drop_count 0, latched index 0.
REQ-030 cmd_ready becomes 1 on the first CLK edge after resetn deasserts.
REQ-031 resetn asserted during STROBE drops the active strobe immediately without waiting for a clock edge; the aborted command produces no frame_done.

Verification
REQ-032 Defaults, ColumnId=0, cmd_data column 0 frame 5 -> FrameStrobe = 20'h00020 for 1 cycle starting 2 cycles after accept, frame_done 1 cycle later, cmd_ready high after 4 cycles.
REQ-033 Column select 5'h1F, frame 19 -> FrameStrobe[19] pulses; column 3 (ColumnId=0) -> no strobe, drop_count 0->1.
REQ-034 Frame index 20 and index 31 with matching column -> no strobe, drop_count increments by 2, busy stays 0.
REQ-035 300 invalid commands -> drop_count reads 255 and holds.
REQ-036 StrobeCycles=3: resetn pulsed low in second strobe cycle -> FrameStrobe 0 within the same cycle, no frame_done, cmd_ready high one edge after resetn release.
REQ-037 cmd_valid held high with changing cmd_data throughout a sequence -> only the first word's frame strobed; next word accepted exactly when cmd_ready returns to 1.
